// File: rtl/mux_scan_capture_if.sv
// Bus bundle between the scan sequencer and whoever owns the 8:1 mux.
// The slave side is the sequencer; the master side drives start/rev and
// returns the mux output y_in for the currently selected index.
interface mux_scan_capture_if #(
  parameter int N_SEL = 3,
  parameter int WIDTH = 8
);
  logic             start;
  logic             rev;
  logic             y_in;
  logic [N_SEL-1:0] sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;

  modport master (
    output start,
    output rev,
    output y_in,
    input  sel,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  rev,
    input  y_in,
    output sel,
    output busy,
    output done,
    output data_out
  );
endinterface

// File: rtl/mux_scan_capture.sv
// Scan sequencer and capture stage for an 8:1 mux. A start pulse walks the
// mux select over every index (ascending or descending), samples the mux
// output once per index after an optional settle delay, and publishes the
// rebuilt parallel word on data_out together with a one-cycle done pulse.
module mux_scan_capture #(
  parameter int N_SEL  = 3,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              reset,
  mux_scan_capture_if.slave bus
);

  // Elaboration-time guards on the parameter set.
  if (WIDTH != (2 ** N_SEL)) begin : g_width_check
    $error("mux_scan_capture: WIDTH must equal 2**N_SEL");
  end
  if ((SETTLE < 0) || (SETTLE > 15)) begin : g_settle_check
    $error("mux_scan_capture: SETTLE must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_SEL-1:0] IDX_FIRST = '0;
  localparam logic [N_SEL-1:0] IDX_LAST  = N_SEL'(WIDTH - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

  state_t           state;
  logic             rev_q;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_next;
  logic             last_idx;
  logic [N_SEL-1:0] sel_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] data_r;

  // Index step in N_SEL-bit unsigned arithmetic; the scan ends before any
  // wrap could occur, so the modular result is never observed at the ends.
  function automatic logic [N_SEL-1:0] step_idx(input logic [N_SEL-1:0] idx,
                                                 input logic             down);
    return down ? (idx - N_SEL'(1)) : (idx + N_SEL'(1));
  endfunction

  // Capture word with the current mux output merged in at the selected bit,
  // so the final index lands in data_out on the same edge it is sampled.
  always_comb begin
    cap_next        = cap;
    cap_next[sel_r] = bus.y_in;
  end

  assign last_idx = rev_q ? (sel_r == IDX_FIRST) : (sel_r == IDX_LAST);

  // Sequencer FSM with registered outputs; reset aborts any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rev_q    <= 1'b0;
      wait_cnt <= '0;
      cap      <= '0;
      sel_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      data_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          sel_r  <= IDX_FIRST;
          if (bus.start) begin
            state    <= SCAN;
            busy_r   <= 1'b1;
            rev_q    <= bus.rev;
            wait_cnt <= SETTLE_LD;
            sel_r    <= bus.rev ? IDX_LAST : IDX_FIRST;
          end
        end
        SCAN: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            cap <= cap_next;
            if (last_idx) begin
              state  <= DONE;
              data_r <= cap_next;
              done_r <= 1'b1;
              busy_r <= 1'b0;
              sel_r  <= IDX_FIRST;
            end else begin
              sel_r    <= step_idx(sel_r, rev_q);
              wait_cnt <= SETTLE_LD;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
          sel_r  <= IDX_FIRST;
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
          sel_r  <= IDX_FIRST;
        end
      endcase
    end
  end

  assign bus.sel      = sel_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.data_out = data_r;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: two instances (SETTLE=0 and SETTLE=2),
// each fed from its own 8:1 mux model indexed by the DUT's sel output.
module tb_mux_scan_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_scan_capture_if #(.N_SEL(3), .WIDTH(8)) b0 ();
  mux_scan_capture_if #(.N_SEL(3), .WIDTH(8)) b2 ();

  logic [7:0] mux0;
  logic [7:0] mux2;

  assign b0.y_in = mux0[b0.sel];
  assign b2.y_in = mux2[b2.sel];

  mux_scan_capture #(.N_SEL(3), .WIDTH(8), .SETTLE(0)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  mux_scan_capture #(.N_SEL(3), .WIDTH(8), .SETTLE(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan on the SETTLE=0 instance. restart_at pulses start at that scan
  // cycle; flip_at replaces the mux input word at that scan cycle.
  task automatic scan0(input string tag, input logic r, input logic [7:0] i_word,
                       input logic [7:0] exp_word, input logic [7:0] prev_word,
                       input int restart_at, input int flip_at, input logic [7:0] flip_word);
    mux0     = i_word;
    b0.rev   = r;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.rev   = ~r;
    for (int c = 0; c < 8; c++) begin
      if (c == flip_at) mux0 = flip_word;
      chk({tag, "_sel"},  32'(b0.sel), r ? (7 - c) : c);
      chk({tag, "_busy"}, 32'(b0.busy), 1);
      chk({tag, "_done_early"}, 32'(b0.done), 0);
      chk({tag, "_hold"}, 32'(b0.data_out), 32'(prev_word));
      b0.start = (c == restart_at);
      tick();
      b0.start = 1'b0;
    end
    chk({tag, "_done"},     32'(b0.done), 1);
    chk({tag, "_busy_end"}, 32'(b0.busy), 0);
    chk({tag, "_sel_end"},  32'(b0.sel), 0);
    chk({tag, "_data"},     32'(b0.data_out), 32'(exp_word));
    tick();
    chk({tag, "_done_pulse"}, 32'(b0.done), 0);
    chk({tag, "_data_hold"},  32'(b0.data_out), 32'(exp_word));
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_idle_busy"}, 32'(b0.busy), 0);
      chk({tag, "_idle_done"}, 32'(b0.done), 0);
      tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    b0.start = 1'b0;
    b0.rev   = 1'b0;
    b2.start = 1'b0;
    b2.rev   = 1'b0;
    mux0     = 8'h00;
    mux2     = 8'h00;
    tick();
    tick();
    chk("rst_sel",  32'(b0.sel), 0);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_data", 32'(b0.data_out), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(b0.busy), 0);

    // Ascending scan.
    scan0("asc", 1'b0, 8'b10110110, 8'b10110110, 8'h00, -1, -1, 8'h00);
    // Descending scan; rev is flipped during the scan and must be ignored.
    scan0("desc", 1'b1, 8'b11001011, 8'b11001011, 8'b10110110, -1, -1, 8'h00);
    // start pulsed again at scan cycle 3 is ignored.
    scan0("restart", 1'b0, 8'h3C, 8'h3C, 8'b11001011, 3, -1, 8'h00);

    // SETTLE=2 instance: each index held three cycles, done at cycle 24.
    mux2     = 8'hA5;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk("settle_sel",  32'(b2.sel), c / 3);
      chk("settle_busy", 32'(b2.busy), 1);
      chk("settle_done_early", 32'(b2.done), 0);
      tick();
    end
    chk("settle_done", 32'(b2.done), 1);
    chk("settle_data", 32'(b2.data_out), 32'hA5);
    tick();
    chk("settle_done_pulse", 32'(b2.done), 0);

    // Reset in the middle of a scan clears everything on the next edge.
    mux0     = 8'hFF;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    repeat (4) tick();
    chk("abort_busy_pre", 32'(b0.busy), 1);
    reset = 1'b1;
    tick();
    chk("abort_sel",  32'(b0.sel), 0);
    chk("abort_busy", 32'(b0.busy), 0);
    chk("abort_done", 32'(b0.done), 0);
    chk("abort_data", 32'(b0.data_out), 0);
    chk("abort_data2", 32'(b2.data_out), 0);
    reset = 1'b0;
    tick();
    scan0("after_rst", 1'b0, 8'h5A, 8'h5A, 8'h00, -1, -1, 8'h00);

    // Mux input changes from 00 to FF just before index 4 is sampled.
    scan0("flip", 1'b0, 8'h00, 8'hF0, 8'h5A, -1, 4, 8'hFF);

    // reset and start together: reset wins, no scan begins.
    reset    = 1'b1;
    b0.start = 1'b1;
    tick();
    reset    = 1'b0;
    b0.start = 1'b0;
    chk("rst_start_busy", 32'(b0.busy), 0);
    tick();
    chk("rst_start_busy2", 32'(b0.busy), 0);
    chk("rst_start_sel",   32'(b0.sel), 0);
    chk("rst_start_data",  32'(b0.data_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
